// File: rtl/long_multiplier_pkg.sv
// Shared types and constants for the shift-add multiplier-accumulator.
// The default operand width matches the companion array divider.
package mul_pkg;

   localparam int WIDTH = 4;
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } mul_state_t;

endpackage

// File: rtl/long_multiplier_if.sv
// Start/busy/done handshake plus operand and result bus of the multiplier.
// The master drives operands and start; the slave returns status and result.
interface long_multiplier_if;
   import mul_pkg::*;

   logic                   start;
   logic [WIDTH-1:0]       m;
   logic [WIDTH-1:0]       q;
   logic [WIDTH-1:0]       r;
   logic                   busy;
   logic                   done;
   logic [2*WIDTH-1:0]     d;
   logic                   ovf;

   modport master (
      output start, m, q, r,
      input  busy, done, d, ovf
   );

   modport slave (
      input  start, m, q, r,
      output busy, done, d, ovf
   );

endinterface

// File: rtl/long_multiplier_rc_adder.sv
// Parameterised ripple-carry adder built from full-adder cells,
// same cell structure as the divider's RC array.
module rc_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         c_i,
   output logic [N-1:0] s_o,
   output logic         c_o
);

   logic [N:0] carry;

   assign carry[0] = c_i;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
      assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
   end

   assign c_o = carry[N];

endmodule

// File: rtl/long_multiplier.sv
// Sequential multiplier-accumulator D = Q*M + R, one partial product per clock.
// Rebuilds the dividend from the divider's quotient, divisor and remainder.
module long_multiplier
   import mul_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   long_multiplier_if.slave   mul_if
);

   mul_state_t           state_q, state_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   d_q, d_d;
   logic                 ovf_q, ovf_d;

   logic [2*WIDTH-1:0]   addend;
   logic [2*WIDTH-1:0]   sum;
   logic [2*WIDTH-1:0]   acc_step;
   logic                 add_cout_unused;

   // The accumulator can never overflow, so the carry out is discarded.
   assign addend = {{WIDTH{1'b0}}, m_q} << cnt_q;

   rc_adder #(.N(2 * WIDTH)) u_adder (
      .a_i (acc_q),
      .b_i (addend),
      .c_i (1'b0),
      .s_o (sum),
      .c_o (add_cout_unused)
   );

   assign acc_step = q_q[0] ? sum : acc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         m_q     <= '0;
         q_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         d_q     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         q_q     <= q_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      q_d     = q_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (mul_if.start) begin
               m_d     = mul_if.m;
               q_d     = mul_if.q;
               acc_d   = {{WIDTH{1'b0}}, mul_if.r};
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_step;
            q_d   = q_q >> 1;
            cnt_d = cnt_q + 1'b1;
            // Result registers load with the final partial sum on the way into DONE.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = DONE;
               d_d     = acc_step;
               ovf_d   = acc_step[2*WIDTH-1];
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mul_if.busy = (state_q == RUN);
   assign mul_if.done = (state_q == DONE);
   assign mul_if.d    = d_q;
   assign mul_if.ovf  = ovf_q;

endmodule

// File: tb/tb_long_multiplier.sv
// Self-checking bench for long_multiplier: directed vectors, back-to-back starts,
// mid-run reset and a divider round-trip sweep.
module tb_long_multiplier;
   import mul_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   long_multiplier_if mif ();

   long_multiplier dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .mul_if (mif)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] m;
      logic [3:0] q;
      logic [3:0] r;
      logic [7:0] d;
      logic       ovf;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [3:0] m, input logic [3:0] q, input logic [3:0] r,
                         output logic [7:0] d, output logic ovf, output int lat,
                         output int busy_n, output int overlap, output bit timeout);
      d = '0; ovf = 1'b0; lat = 0; busy_n = 0; overlap = 0; timeout = 1'b1;
      @(negedge clk);
      mif.start = 1'b1; mif.m = m; mif.q = q; mif.r = r;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         mif.start = 1'b0;
         if (mif.busy) busy_n++;
         if (mif.busy && mif.done) overlap++;
         if (mif.done) begin
            lat = i + 1; d = mif.d; ovf = mif.ovf; timeout = 1'b0;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [3:0] pm(input int c); return 4'((c + 1) & 15); endfunction
   function automatic logic [3:0] pq(input int c); return 4'((3 * c + 5) & 15); endfunction
   function automatic logic [3:0] pr(input int c); return 4'((5 * c + 2) & 15); endfunction

   initial begin
      logic [7:0] d, prev_d, exp_d;
      logic       ovf;
      int lat, busy_n, overlap, n_done, exp_edge;
      bit timeout;
      int rq, rr;

      vecs[0] = '{m: 4'd5,  q: 4'd9,  r: 4'd3,  d: 8'd48,  ovf: 1'b0};
      vecs[1] = '{m: 4'd15, q: 4'd15, r: 4'd15, d: 8'd240, ovf: 1'b1};
      vecs[2] = '{m: 4'd1,  q: 4'd0,  r: 4'd7,  d: 8'd7,   ovf: 1'b0};
      vecs[3] = '{m: 4'd0,  q: 4'd13, r: 4'd6,  d: 8'd6,   ovf: 1'b0};
      vecs[4] = '{m: 4'd12, q: 4'd11, r: 4'd9,  d: 8'd141, ovf: 1'b1};
      vecs[5] = '{m: 4'd7,  q: 4'd7,  r: 4'd0,  d: 8'd49,  ovf: 1'b0};
      vecs[6] = '{m: 4'd3,  q: 4'd0,  r: 4'd0,  d: 8'd0,   ovf: 1'b0};
      vecs[7] = '{m: 4'd15, q: 4'd1,  r: 4'd0,  d: 8'd15,  ovf: 1'b0};
      vecs[8] = '{m: 4'd10, q: 4'd12, r: 4'd15, d: 8'd135, ovf: 1'b1};

      mif.start = 1'b0; mif.m = '0; mif.q = '0; mif.r = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 32'(mif.busy), 0);
      check("reset_done", 32'(mif.done), 0);
      check("reset_d",    32'(mif.d),    0);
      check("reset_ovf",  32'(mif.ovf),  0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vector table
      foreach (vecs[i]) begin
         run_op(vecs[i].m, vecs[i].q, vecs[i].r, d, ovf, lat, busy_n, overlap, timeout);
         check($sformatf("vec%0d_timeout", i), 32'(timeout), 0);
         check($sformatf("vec%0d_d", i),       32'(d),       32'(vecs[i].d));
         check($sformatf("vec%0d_ovf", i),     32'(ovf),     32'(vecs[i].ovf));
         check($sformatf("vec%0d_latency", i), 32'(lat),     5);
         check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 4);
         check($sformatf("vec%0d_busy_done_overlap", i), 32'(overlap), 0);
      end

      // D/ovf hold their previous value throughout a new RUN
      prev_d = 8'd135;
      @(negedge clk);
      mif.start = 1'b1; mif.m = 4'd2; mif.q = 4'd3; mif.r = 4'd1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         mif.start = 1'b0; mif.m = 4'd15; mif.q = 4'd15; mif.r = 4'd15;
         check($sformatf("hold_busy%0d", i), 32'(mif.busy), 1);
         check($sformatf("hold_d%0d", i),    32'(mif.d),    32'(prev_d));
         check($sformatf("hold_ovf%0d", i),  32'(mif.ovf),  1);
      end
      @(posedge clk); #1;
      check("hold_done", 32'(mif.done), 1);
      check("hold_result", 32'(mif.d), 7);
      @(posedge clk); #1;

      // start held for 20 cycles with changing operands: accepts at edges 0,6,12,18
      n_done = 0;
      for (int c = 0; c < 26; c++) begin
         @(negedge clk);
         mif.start = (c < 20);
         mif.m = pm(c); mif.q = pq(c); mif.r = pr(c);
         @(posedge clk); #1;
         if (mif.done) begin
            if (n_done < 4) begin
               exp_edge = 4 + 6 * n_done;
               exp_d = 8'(pq(6 * n_done) * pm(6 * n_done) + pr(6 * n_done));
               check($sformatf("burst%0d_edge", n_done), 32'(c), 32'(exp_edge));
               check($sformatf("burst%0d_d", n_done), 32'(mif.d), 32'(exp_d));
            end
            n_done++;
         end
      end
      mif.start = 1'b0;
      check("burst_done_count", 32'(n_done), 4);

      // Reset asserted in the second RUN cycle aborts the operation
      @(negedge clk);
      mif.start = 1'b1; mif.m = 4'd9; mif.q = 4'd6; mif.r = 4'd2;
      @(posedge clk); #1;
      mif.start = 1'b0;
      check("abort_busy_before", 32'(mif.busy), 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(mif.busy), 0);
      check("abort_done", 32'(mif.done), 0);
      check("abort_d",    32'(mif.d),    0);
      check("abort_ovf",  32'(mif.ovf),  0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (mif.done) n_done++;
         if (mif.busy) n_done++;
      end
      check("abort_no_activity", 32'(n_done), 0);
      run_op(4'd9, 4'd6, 4'd2, d, ovf, lat, busy_n, overlap, timeout);
      check("after_abort_timeout", 32'(timeout), 0);
      check("after_abort_d",       32'(d),       56);
      check("after_abort_latency", 32'(lat),     5);

      // Divider round trip over all in-range operands
      for (int m = 1; m < 16; m++) begin
         for (int q = 0; q < 8; q++) begin
            for (int r = 0; r < m; r++) begin
               run_op(4'(m), 4'(q), 4'(r), d, ovf, lat, busy_n, overlap, timeout);
               rq = int'(d) / m;
               rr = int'(d) % m;
               check($sformatf("rt_m%0d_q%0d_r%0d", m, q, r),
                     {timeout, ovf, 6'(rq), 4'(rr)}, {1'b0, 1'b0, 6'(q), 4'(r)});
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
